multiword_add_seq: RTL

Sequential multi-precision adder/subtractor that adds two WORDS×WIDTH-bit operands one limb per cycle. It wraps a single WIDTH-bit `ripple_carry_adder` and carries between limbs through a register. It sits directly upstream of the adder: it slices operands into limbs, drives `a`/`b`/`cin`, and assembles `sum`/`cout` into a full-width result. Valid/ready handshakes are used on both sides.

---
 rtl/multiword_add_pkg.sv | 21 ++
 rtl/ripple_carry_adder.sv | 34 +++
 rtl/multiword_add_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/multiword_add_pkg.sv
// ---------------------------------------------------------------------------
// multiword_add_pkg
// Shared definitions for the sequential multi-precision adder/subtractor.
//   state_e   : controller states (IDLE, RUN, DONE) with a fixed 2-bit encoding
//   idxWidth  : width of the limb index register for a given limb count
// No ports; imported by multiword_add_seq.
// ---------------------------------------------------------------------------
package multiword_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Width of the limb index. A single limb would still need one bit.
    function automatic int idxWidth(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// ---------------------------------------------------------------------------
// ripple_carry_adder
// Purely combinational WIDTH-bit adder built from a chain of full adders.
// Ports:
//   a, b  in  WIDTH : addends
//   cin   in  1     : carry into bit 0
//   sum   out WIDTH : a + b + cin, modulo 2^WIDTH
//   cout  out 1     : carry out of the top bit
// ---------------------------------------------------------------------------
module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Walk the carry up through the bits one full adder at a time. The carry
    // is a local variable so the chain is a straight sequence of statements
    // rather than a vector that feeds back on itself.
    always_comb begin
        logic carry;
        sum   = '0;
        carry = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/multiword_add_seq.sv
// ---------------------------------------------------------------------------
// multiword_add_seq
// Sequential multi-precision adder/subtractor. Adds two WORDS*WIDTH-bit
// operands one WIDTH-bit limb per cycle through a single ripple_carry_adder,
// carrying between limbs through a register. Subtraction is A + ~B + 1.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   in_a, in_b           : operands, WIDTH*WORDS bits
//   in_cin               : carry-in for addition (ignored when in_sub=1)
//   in_sub               : 1 selects A - B
//   out_valid / out_ready: result handshake (out_valid high only in DONE)
//   out_sum              : result, modulo 2^(WIDTH*WORDS)
//   out_cout             : carry out of the top limb (1 = no borrow on subtract)
//   out_ovf              : signed overflow
//
// Build option:
//   MULTIWORD_ADD_OVF_EN : when defined, out_ovf reports two's-complement
//                          overflow; otherwise out_ovf is tied to 0.
// ---------------------------------------------------------------------------
module multiword_add_seq
    import multiword_add_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH*WORDS-1:0]   in_a,
    input  logic [WIDTH*WORDS-1:0]   in_b,
    input  logic                     in_cin,
    input  logic                     in_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*WORDS-1:0]   out_sum,
    output logic                     out_cout,
    output logic                     out_ovf
);

    localparam int W    = WIDTH * WORDS;
    localparam int IDXW = idxWidth(WORDS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     opA_q, opB_q, sum_q;
    logic             carry_q, cout_q;
    logic [IDXW-1:0]  idx_q;

    logic [31:0]      limbBase;
    logic [W-1:0]     limbMask;
    logic [WIDTH-1:0] limbA, limbB, limbSum;
    logic             limbCout;
    logic             accept, lastLimb;

    assign accept   = (state_q == IDLE) && in_valid;
    assign lastLimb = (state_q == RUN) && (idx_q == LAST_IDX);

    // Select the current limb by shifting it down to bit 0; the same offset
    // is used to drop the adder result back into its slot of the sum.
    assign limbBase = 32'(idx_q) * 32'(WIDTH);
    assign limbMask = W'({WIDTH{1'b1}}) << limbBase;
    assign limbA    = WIDTH'(opA_q >> limbBase);
    assign limbB    = WIDTH'(opB_q >> limbBase);

    ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (limbA),
        .b    (limbB),
        .cin  (carry_q),
        .sum  (limbSum),
        .cout (limbCout)
    );

    // Controller: accept an operand set in IDLE, step through the limbs in
    // RUN, then hold the result in DONE until the consumer takes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)          state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    if (out_ready)         state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath. Subtraction is folded in at capture time by inverting B and
    // forcing the initial carry, so RUN only ever adds. The sum is cleared on
    // capture and filled one limb per cycle; the final carry is kept as cout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opA_q   <= '0;
            opB_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            opA_q   <= in_a;
            opB_q   <= in_sub ? ~in_b : in_b;
            carry_q <= in_sub ? 1'b1 : in_cin;
            idx_q   <= '0;
            sum_q   <= '0;
        end else if (state_q == RUN) begin
            sum_q   <= (sum_q & ~limbMask) | ((W'(limbSum) << limbBase) & limbMask);
            carry_q <= limbCout;
            idx_q   <= idx_q + 1'b1;
            if (lastLimb) begin
                cout_q <= limbCout;
            end
        end
    end

`ifdef MULTIWORD_ADD_OVF_EN
    logic ovf_q;

    // Signed overflow: both top-limb operands share a sign and the top-limb
    // sum has the other sign. B is already inverted for subtraction here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (lastLimb) begin
            ovf_q <= (limbA[WIDTH-1] == limbB[WIDTH-1]) &&
                     (limbSum[WIDTH-1] != limbA[WIDTH-1]);
        end
    end

    assign out_ovf = ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule
